// File: rtl/uart_rx_multi_sampler.sv
// UART RX majority-vote sampler: synchronises rx_in, collects an odd number of
// samples centred on the bit midpoint and resolves them to a bit plus a noise flag.
module uart_rx_multi_sampler #(
    parameter int unsigned PWIDTH      = 6,
    parameter int unsigned MAX_SAMPLES = 7,
    parameter int unsigned SWIDTH      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [PWIDTH-1:0] edge_cnt,
    input  logic              sample_en,
    input  logic [SWIDTH-1:0] nsamp,
    input  logic              rx_in,
    output logic              sampled_bit,
    output logic              sample_valid,
    output logic              noise_err
);

    localparam int unsigned CW = ((PWIDTH > SWIDTH) ? PWIDTH : SWIDTH) + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SWIDTH-1:0]      ones_q, ones_d;
    logic [SWIDTH-1:0]      count_q, count_d;
    logic                   sampled_bit_q, sampled_bit_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   noise_err_q, noise_err_d;

    logic                   rx_sync;
    logic [SWIDTH-1:0]      n_req, n_eff;
    logic [PWIDTH-1:0]      half, mid, first, last;
    logic                   in_win;
    logic                   resolve;
    logic [SWIDTH-1:0]      ones_total;
    logic [SWIDTH:0]        ones_x2;

    // Shift register synchroniser; the oldest stage feeds the sampler.
    always_comb begin
        sync_d = SYNC_STAGES'(sync_q << 1) | SYNC_STAGES'(rx_in);
    end
    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Force an odd count within MAX_SAMPLES, and fall back to one sample when
    // the bit period is too short to hold the window with a margin.
    always_comb begin
        n_req = nsamp;
        if (nsamp == '0) begin
            n_req = SWIDTH'(1);
        end else if (!nsamp[0]) begin
            n_req = nsamp - SWIDTH'(1);
        end
        if (CW'(n_req) > CW'(MAX_SAMPLES)) begin
            n_req = SWIDTH'(MAX_SAMPLES);
        end
        n_eff = n_req;
        if (CW'(prescale) < CW'(n_req) + CW'(2)) begin
            n_eff = SWIDTH'(1);
        end
    end

    assign half   = PWIDTH'(n_eff >> 1);
    assign mid    = prescale >> 1;
    assign first  = mid - half;
    assign last   = mid + half;
    assign in_win = (edge_cnt >= first) && (edge_cnt <= last);

    always_comb begin
        state_d        = state_q;
        ones_d         = ones_q;
        count_d        = count_q;
        sampled_bit_d  = sampled_bit_q;
        noise_err_d    = noise_err_q;
        sample_valid_d = 1'b0;
        resolve        = 1'b0;
        ones_total     = ones_q + SWIDTH'(rx_sync);
        ones_x2        = '0;

        case (state_q)
            IDLE: begin
                if (sample_en && (edge_cnt == first)) begin
                    ones_total = SWIDTH'(rx_sync);
                    if (edge_cnt == last) begin
                        resolve = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        ones_d  = ones_total;
                        count_d = SWIDTH'(1);
                    end
                end
            end
            COLLECT: begin
                // Enable loss, counter resync or an overrun abandons the window silently.
                if (!sample_en || !in_win || (count_q >= n_eff)) begin
                    state_d = IDLE;
                    ones_d  = '0;
                    count_d = '0;
                end else if (edge_cnt == last) begin
                    resolve = 1'b1;
                end else begin
                    ones_d  = ones_total;
                    count_d = count_q + SWIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resolve) begin
            ones_x2        = {ones_total, 1'b0};
            state_d        = IDLE;
            ones_d         = '0;
            count_d        = '0;
            sample_valid_d = 1'b1;
            sampled_bit_d  = ones_x2 > {1'b0, n_eff};
            noise_err_d    = (ones_total != '0) && (ones_total != n_eff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sync_q         <= '1;
            ones_q         <= '0;
            count_q        <= '0;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
            noise_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            ones_q         <= ones_d;
            count_q        <= count_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            noise_err_q    <= noise_err_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign noise_err    = noise_err_q;

endmodule

// File: doc/uart_rx_multi_sampler.md
Name: uart_rx_multi_sampler

Overview:
Parametrised successor to the UART RX single-window data sampler. It synchronises rx_in, then takes a programmable odd number of samples centred on the bit midpoint and resolves them by majority vote. It emits a one-cycle sample_valid strobe, the voted bit, and a noise flag when the samples disagree. It sits between the RX edge/bit counter and the RX FSM, deserializer and parity/stop checkers, with one instance per RX channel.

Parameters:
PWIDTH, 6, width of prescale and edge_cnt.
MAX_SAMPLES, 7, largest supported odd sample count (>=1, odd).
SWIDTH, 3, width of nsamp; must satisfy 2^SWIDTH > MAX_SAMPLES.
SYNC_STAGES, 2, rx_in synchroniser depth (>=1).

Ports:
clk  input  1  system clock (oversampling clock).
rst  input  1  asynchronous, active-low reset.
prescale  input  PWIDTH  oversampling ratio (clocks per bit, e.g. 8/16/32).
edge_cnt  input  PWIDTH  edge counter from the bit counter, counts 0..prescale-1.
sample_en  input  1  sampling enable from the RX FSM.
nsamp  input  SWIDTH  requested sample count (odd, 1..MAX_SAMPLES).
rx_in  input  1  asynchronous serial line.
sampled_bit  output  1  voted bit value.
sample_valid  output  1  one-cycle strobe; sampled_bit and noise_err are updated.
noise_err  output  1  samples in the last window were not unanimous.

Behaviour:
- Reset (rst=0, async):
  - Synchroniser flops reset to 1 (idle line).
  - sampled_bit=1, sample_valid=0, noise_err=0.
  - ones/count cleared; FSM goes to IDLE.
- Synchroniser: rx_sync is rx_in delayed through SYNC_STAGES flops. All sampling uses rx_sync only.
- Effective count n_eff, resolved combinationally:
  - nsamp=0 gives 1.
  - Even nsamp gives nsamp-1.
  - nsamp>MAX_SAMPLES gives MAX_SAMPLES.
  - If prescale < n_eff+2, then n_eff=1.
- Window bounds:
  - half=n_eff>>1, mid=prescale>>1.
  - first=mid-half, last=mid+half.
  - Arithmetic is PWIDTH bits with no wrap; the clamps above guarantee last<=prescale-1.
- FSM states IDLE and COLLECT:
  - IDLE -> COLLECT when sample_en && edge_cnt==first. This cycle's rx_sync is sampled: ones=rx_sync, count=1.
  - In COLLECT, each cycle with sample_en && first<=edge_cnt<=last samples rx_sync: ones+=rx_sync, count+=1.
  - When edge_cnt==last in either state, that cycle's sample is the final one. The block resolves it and returns to IDLE.
  - If n_eff=1, first==last, so the block samples and resolves in the same cycle without entering COLLECT.
- Resolve, registered, visible the cycle after the last sample:
  - sampled_bit = (2*ones_total > n_eff).
  - noise_err = (ones_total!=0 && ones_total!=n_eff).
  - sample_valid=1 for exactly one cycle.
  - ones/count are cleared.
- sampled_bit and noise_err hold their values between strobes. sample_valid=0 otherwise.
- sample_en deasserted while in COLLECT: abort. The block returns to IDLE, clears ones/count, and produces no strobe; outputs hold.
- edge_cnt jumping outside [first,last] while in COLLECT (counter resync): abort, same as above.
- nsamp or prescale changing mid-window: the window bounds use current values each cycle. This is not supported; software changes them only while sample_en=0.
- Back-to-back bits: a new window may start on any cycle after resolve. There is no dead time beyond edge_cnt progression.
- Latency: rx_in to first sample is SYNC_STAGES cycles. Last sample to sample_valid is 1 cycle.
- ones and count are SWIDTH bits wide and cannot overflow, because count<=n_eff<=MAX_SAMPLES.

Test Plan:
- Reset value check: assert rst=0 mid-window, e.g. prescale=8, nsamp=3, edge_cnt=4 -> sampled_bit=1, sample_valid=0, noise_err=0 immediately; no strobe after release until a new full window.
- Noisy majority: prescale=8, nsamp=3 (window edges 3,4,5), rx_sync=1,0,1 -> one cycle after edge 5: sample_valid=1, sampled_bit=1, noise_err=1.
- Clean zero with wide window: prescale=16, nsamp=5 (edges 6..10), rx_sync=0 throughout -> sampled_bit=0, noise_err=0, exactly one strobe per 16 clocks over 10 consecutive bits.
- Clamping:
  - nsamp=4, prescale=8 -> behaves as 3 (edges 3..5).
  - nsamp=7, prescale=8 -> n_eff=1 (edge 4 only); rx_sync=0 at edge 4 with 1 elsewhere -> sampled_bit=0, noise_err=0.
- Abort: prescale=8, nsamp=3, drop sample_en at edge 4 -> no sample_valid that bit. The next window with rx_sync=1,1,1 -> sampled_bit=1, noise_err=0, proving the counters were cleared.
- Synchroniser latency: SYNC_STAGES=2; toggle rx_in exactly 2 cycles before edge 4 with nsamp=1 -> the new value is captured; toggling 1 cycle before is not captured.
